// File: rtl/uart_rx_depacketizer.sv
// uart_rx_depacketizer: oversampled UART receiver. It frames start/data/stop bits
// sampled at mid-bit and pushes good bytes into a downstream RX FIFO. Framing,
// overrun and parity errors are reported as one-cycle pulses.
// Optional even-parity framing (8E1) is enabled by defining UART_RX_PARITY_EN.
module uart_rx_depacketizer #(
   parameter int BAUD_RATE    = 115200,
   parameter int CLK_FREQ     = 50000000,
   parameter int DATA_WIDTH   = 8,
   parameter int OVERSAMPLE   = 16,
   parameter int SAMPLE_COUNT = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  serial_in,
   input  logic                  fifo_full,
   output logic                  fifo_write_en,
   output logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  rx_busy,
   output logic                  frame_err,
   output logic                  overrun_err,
   output logic                  parity_err,
   output logic [2:0]            debug_state
);

   localparam int CNT_W = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
   localparam int IDX_W = $clog2(OVERSAMPLE);
   localparam int BC_W  = $clog2(DATA_WIDTH);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SAMPLE_COUNT - 1);
   localparam logic [IDX_W-1:0] HALF_M1  = IDX_W'(OVERSAMPLE / 2 - 1);
   localparam logic [IDX_W-1:0] OS_M1    = IDX_W'(OVERSAMPLE - 1);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      WRITE  = 3'd5,
      RESYNC = 3'd6
   } state_t;

   state_t                  state, state_nxt;
   logic                    rx_p0, rx_s, rx_prev;
   logic [CNT_W-1:0]        tick_cnt;
   logic                    tick, start_edge;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic [BC_W-1:0]         bit_cnt, bit_cnt_nxt;
   logic [DATA_WIDTH-1:0]   shift_reg, shift_nxt;
   logic                    wr_nxt, ferr_nxt, oerr_nxt;
   logic [DATA_WIDTH-1:0]   data_nxt;
`ifdef UART_RX_PARITY_EN
   logic                    par_bad, par_bad_nxt, perr_nxt;
`endif

   // Two-flop synchroniser on the asynchronous line, plus a delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_p0   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_p0   <= serial_in;
         rx_s    <= rx_p0;
         rx_prev <= rx_s;
      end
   end

   assign start_edge = (state == IDLE) && rx_prev && !rx_s;
   assign tick       = (tick_cnt == CNT_MAX);
   assign rx_busy    = (state != IDLE);

   // Sample-tick divider, restarted on the start edge so ticks are phase-aligned to the start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tick_cnt <= '0;
      else if (start_edge || tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + CNT_W'(1);
   end

   // Frame sequencing: next state, sample capture and output pulses
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift_reg;
      wr_nxt      = 1'b0;
      data_nxt    = fifo_data;
      ferr_nxt    = 1'b0;
      oerr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt = par_bad;
      perr_nxt    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start_edge) begin
               state_nxt = START;
               idx_nxt   = '0;
            end
         end
         START: begin
            if (tick) begin
               if (idx == HALF_M1) begin
                  // A start bit that is already high again at mid-bit is treated as line noise
                  if (rx_s) begin
                     state_nxt = IDLE;
                  end else begin
                     state_nxt   = DATA;
                     idx_nxt     = '0;
                     bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                     par_bad_nxt = 1'b0;
`endif
                  end
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (idx == OS_M1) begin
                  idx_nxt            = '0;
                  shift_nxt[bit_cnt] = rx_s;
                  if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_nxt = PARITY;
`else
                     state_nxt = STOP;
`endif
                  end else begin
                     bit_cnt_nxt = bit_cnt + BC_W'(1);
                  end
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (idx == OS_M1) begin
                  idx_nxt     = '0;
                  // Even parity: received bit must equal the XOR of the data bits
                  par_bad_nxt = rx_s ^ (^shift_reg);
                  state_nxt   = STOP;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (idx == OS_M1) begin
                  idx_nxt = '0;
                  if (rx_s) begin
                     state_nxt = WRITE;
                  end else begin
                     ferr_nxt  = 1'b1;
                     state_nxt = RESYNC;
                  end
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         WRITE: begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
               perr_nxt = 1'b1;
            end else
`endif
            if (fifo_full) begin
               oerr_nxt = 1'b1;
            end else begin
               wr_nxt   = 1'b1;
               data_nxt = shift_reg;
            end
         end
         RESYNC: begin
            // Hold off until the line returns high so a break is not taken as a new start bit
            if (rx_s)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and registered output pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         fifo_write_en <= 1'b0;
         fifo_data     <= '0;
         frame_err     <= 1'b0;
         overrun_err   <= 1'b0;
         debug_state   <= 3'd0;
      end else begin
         state         <= state_nxt;
         idx           <= idx_nxt;
         bit_cnt       <= bit_cnt_nxt;
         shift_reg     <= shift_nxt;
         fifo_write_en <= wr_nxt;
         fifo_data     <= data_nxt;
         frame_err     <= ferr_nxt;
         overrun_err   <= oerr_nxt;
         debug_state   <= state;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity mismatch flag and its error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bad    <= par_bad_nxt;
         parity_err <= perr_nxt;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
